// File: rtl/pairhmm_worker_core.sv
`default_nettype none
// ============================================================================
//  Module      : pairhmm_worker_core
//  Description : Per-job sequencer for the PairHMM accelerator. Walks the
//                read x haplotype DP matrix row-major, fetches bases/quals
//                from 1-cycle-latency ROM ports, issues one packed request
//                per cell to the compute engine and captures the final
//                likelihood it returns.
//
//  request_o layout (MSB -> LSB):
//      read_base[8] hap_base[8] q[8] i[8] d[8] c[8]
//      i_right[8] d_right[8] c_right[8]
//      row[ADDR_WIDTH] col[ADDR_WIDTH]
//      first_row last_row first_col last_col
//
//  Revision    : 1.0  initial release
// ============================================================================
module pairhmm_worker_core #(
    parameter  int MAX_SEQUENCE_LENGTH = 2048,
    localparam int ADDR_WIDTH          = $clog2(MAX_SEQUENCE_LENGTH),
    localparam int REQ_WIDTH           = 9 * 8 + 2 * ADDR_WIDTH + 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  enable_i,

    input  logic [ADDR_WIDTH-1:0] read_len_i,
    output logic [ADDR_WIDTH-1:0] read_pos_o,
    output logic                  read_read_o,
    input  logic [7:0]            read_base_i,
    input  logic [7:0]            read_q_i,
    input  logic [7:0]            read_i_i,
    input  logic [7:0]            read_d_i,
    input  logic [7:0]            read_c_i,
    input  logic [7:0]            read_i_right_i,
    input  logic [7:0]            read_d_right_i,
    input  logic [7:0]            read_c_right_i,

    input  logic [ADDR_WIDTH-1:0] hap_len_i,
    output logic [ADDR_WIDTH-1:0] hap_pos_o,
    output logic                  hap_read_o,
    input  logic [7:0]            hap_base_i,

    input  logic                  compute_ready_i,
    output logic [REQ_WIDTH-1:0]  request_o,
    output logic                  write_req_o,

    input  logic                  result_ready_i,
    input  logic [31:0]           result_i,
    output logic                  read_result_o,
    output logic [31:0]           result_o,
    output logic                  result_valid_o
);

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_RES = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_row;
    logic [ADDR_WIDTH-1:0] r_col;
    logic [ADDR_WIDTH-1:0] r_read_len;
    logic [ADDR_WIDTH-1:0] r_hap_len;
    logic [31:0]           r_result;

    logic w_first_row;
    logic w_last_row;
    logic w_first_col;
    logic w_last_col;
    logic w_last_cell;

    // Cell position flags derived from the current indices and latched lengths
    assign w_first_row = (r_row == c_ADDR_ZERO);
    assign w_last_row  = (r_row == (r_read_len - c_ADDR_ONE));
    assign w_first_col = (r_col == c_ADDR_ZERO);
    assign w_last_col  = (r_col == (r_hap_len - c_ADDR_ONE));
    assign w_last_cell = w_last_row && w_last_col;

    // Job sequencer: matrix walk, engine handshake and result capture
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_read_len <= '0;
            r_hap_len  <= '0;
            r_result   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable_i) begin
                        r_read_len <= read_len_i;
                        r_hap_len  <= hap_len_i;
                        r_row      <= '0;
                        r_col      <= '0;
                        // An empty matrix has no cells; finish with a zero likelihood
                        if ((read_len_i == c_ADDR_ZERO) || (hap_len_i == c_ADDR_ZERO)) begin
                            r_result <= '0;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (compute_ready_i) begin
                        if (w_last_cell) begin
                            r_state <= S_WAIT_RES;
                        end else begin
                            if (w_last_col) begin
                                r_col <= '0;
                                r_row <= r_row + c_ADDR_ONE;
                            end else begin
                                r_col <= r_col + c_ADDR_ONE;
                            end
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_WAIT_RES: begin
                    if (result_ready_i) begin
                        r_result <= result_i;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Level-sensitive enable: only a drop re-arms the sequencer
                    if (!enable_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ROM ports follow the indices; enables are active only in FETCH
    assign read_pos_o  = r_row;
    assign hap_pos_o   = r_col;
    assign read_read_o = (r_state == S_FETCH);
    assign hap_read_o  = (r_state == S_FETCH);

    // Request is only meaningful in ISSUE, where the ROM data is stable
    assign request_o = (r_state == S_ISSUE) ?
        {read_base_i, hap_base_i, read_q_i, read_i_i, read_d_i, read_c_i,
         read_i_right_i, read_d_right_i, read_c_right_i,
         r_row, r_col, w_first_row, w_last_row, w_first_col, w_last_col} :
        '0;

    // Handshake strobes are qualified by state so each lasts one accepted cycle
    assign write_req_o    = (r_state == S_ISSUE)    && compute_ready_i;
    assign read_result_o  = (r_state == S_WAIT_RES) && result_ready_i;
    assign result_o       = r_result;
    assign result_valid_o = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pairhmm_worker_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pairhmm_worker_core
//  Description : Self-checking bench for pairhmm_worker_core. ROMs hold random
//                contents per job; every issued request is compared against
//                the cell expected from its ordinal position in the matrix.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pairhmm_worker_core;

    localparam int MAXL = 2048;
    localparam int AW   = 11;
    localparam int RW   = 9 * 8 + 2 * AW + 4;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          enable_i;
    logic [AW-1:0] read_len_i;
    logic [AW-1:0] read_pos_o;
    logic          read_read_o;
    logic [7:0]    read_base_i, read_q_i, read_i_i, read_d_i, read_c_i;
    logic [7:0]    read_i_right_i, read_d_right_i, read_c_right_i;
    logic [AW-1:0] hap_len_i;
    logic [AW-1:0] hap_pos_o;
    logic          hap_read_o;
    logic [7:0]    hap_base_i;
    logic          compute_ready_i;
    logic [RW-1:0] request_o;
    logic          write_req_o;
    logic          result_ready_i;
    logic [31:0]   result_i;
    logic          read_result_o;
    logic [31:0]   result_o;
    logic          result_valid_o;

    // ROM images (one spare entry for the row+1 qualities)
    logic [7:0] rom_base [0:MAXL];
    logic [7:0] rom_q    [0:MAXL];
    logic [7:0] rom_i    [0:MAXL];
    logic [7:0] rom_d    [0:MAXL];
    logic [7:0] rom_c    [0:MAXL];
    logic [7:0] rom_hap  [0:MAXL];

    int tests = 0;
    int fails = 0;
    int req_count = 0;
    int rr_count = 0;
    int rd_count = 0;
    int job_start = 0;
    int cur_rl = 0;
    int cur_hl = 0;
    logic [RW-1:0] last_req = '0;

    pairhmm_worker_core #(.MAX_SEQUENCE_LENGTH(MAXL)) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .read_len_i     (read_len_i),
        .read_pos_o     (read_pos_o),
        .read_read_o    (read_read_o),
        .read_base_i    (read_base_i),
        .read_q_i       (read_q_i),
        .read_i_i       (read_i_i),
        .read_d_i       (read_d_i),
        .read_c_i       (read_c_i),
        .read_i_right_i (read_i_right_i),
        .read_d_right_i (read_d_right_i),
        .read_c_right_i (read_c_right_i),
        .hap_len_i      (hap_len_i),
        .hap_pos_o      (hap_pos_o),
        .hap_read_o     (hap_read_o),
        .hap_base_i     (hap_base_i),
        .compute_ready_i(compute_ready_i),
        .request_o      (request_o),
        .write_req_o    (write_req_o),
        .result_ready_i (result_ready_i),
        .result_i       (result_i),
        .read_result_o  (read_result_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o)
    );

    always #5 clock_i = ~clock_i;

    // 1-cycle-latency ROMs; outputs hold while the enables are low
    always @(posedge clock_i) begin
        if (read_read_o) begin
            read_base_i    <= rom_base[int'(read_pos_o)];
            read_q_i       <= rom_q[int'(read_pos_o)];
            read_i_i       <= rom_i[int'(read_pos_o)];
            read_d_i       <= rom_d[int'(read_pos_o)];
            read_c_i       <= rom_c[int'(read_pos_o)];
            read_i_right_i <= rom_i[int'(read_pos_o) + 1];
            read_d_right_i <= rom_d[int'(read_pos_o) + 1];
            read_c_right_i <= rom_c[int'(read_pos_o) + 1];
        end
        if (hap_read_o) begin
            hap_base_i <= rom_hap[int'(hap_pos_o)];
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected request for the n-th cell of a row-major walk
    function automatic logic [RW-1:0] exp_req(input int n);
        int r;
        int c;
        r = n / cur_hl;
        c = n % cur_hl;
        return {rom_base[r], rom_hap[c], rom_q[r], rom_i[r], rom_d[r], rom_c[r],
                rom_i[r+1], rom_d[r+1], rom_c[r+1], AW'(r), AW'(c),
                (r == 0), (r == cur_rl - 1), (c == 0), (c == cur_hl - 1)};
    endfunction

    // One clock: observe outputs at the falling edge, return just after the rising edge
    task automatic step();
        int n;
        @(negedge clock_i);
        if (write_req_o) begin
            n = req_count - job_start;
            check("req_in_range", 128'(n < cur_rl * cur_hl), 128'(1));
            if (n < cur_rl * cur_hl) check("req_content", request_o, exp_req(n));
            last_req = request_o;
            req_count++;
        end
        if (read_result_o) rr_count++;
        if (read_read_o || hap_read_o) begin
            check("rom_enables", {read_read_o, hap_read_o}, 2'b11);
            rd_count++;
        end
        @(posedge clock_i);
        #1;
    endtask

    task automatic start_job(input int rl, input int hl);
        for (int k = 0; k <= MAXL; k++) begin
            rom_base[k] = 8'($urandom);
            rom_q[k]    = 8'($urandom);
            rom_i[k]    = 8'($urandom);
            rom_d[k]    = 8'($urandom);
            rom_c[k]    = 8'($urandom);
            rom_hap[k]  = 8'($urandom);
        end
        cur_rl     = rl;
        cur_hl     = hl;
        job_start  = req_count;
        read_len_i = AW'(rl);
        hap_len_i  = AW'(hl);
        enable_i   = 1'b1;
    endtask

    task automatic wait_reqs(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while ((req_count - job_start) < target && k < budget) begin
            step();
            k++;
        end
        check(tag, 128'(req_count - job_start), 128'(target));
    endtask

    task automatic finish_job(input logic [31:0] val);
        int rr0;
        int k;
        repeat (10) step();
        check("req_total", 128'(req_count - job_start), 128'(cur_rl * cur_hl));
        rr0 = rr_count;
        result_i = val;
        result_ready_i = 1'b1;
        k = 0;
        while (rr_count == rr0 && k < 40) begin
            step();
            k++;
        end
        result_ready_i = 1'b0;
        check("result_valid", 128'(result_valid_o), 128'(1));
        check("result_value", 128'(result_o), 128'(val));
        step();
        check("rr_pulses", 128'(rr_count - rr0), 128'(1));
        check("valid_held", 128'(result_valid_o), 128'(1));
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({read_pos_o, read_read_o, hap_pos_o, hap_read_o, request_o,
                     write_req_o, read_result_o});
    endfunction

    initial begin
        logic [RW-1:0] held;
        logic [31:0]   rv;
        int            rq0;
        int            rd0;

        reset_i = 1'b0;
        enable_i = 1'b0;
        read_len_i = '0;
        hap_len_i = '0;
        compute_ready_i = 1'b1;
        result_ready_i = 1'b0;
        result_i = '0;
        repeat (3) @(posedge clock_i);
        #1;
        check("reset_outs", all_outs(), 128'(0));
        check("reset_result", 128'({result_o, result_valid_o}), 128'(0));
        reset_i = 1'b1;
        step();

        // 41x41 job with a backpressure window and an ignored enable drop
        start_job(41, 41);
        wait_reqs("wait_300", 300, 2000);
        compute_ready_i = 1'b0;
        enable_i = 1'b0;
        step();
        step();
        held = request_o;
        check("bp_cell", held, exp_req(req_count - job_start));
        rq0 = req_count;
        for (int k = 0; k < 20; k++) begin
            step();
            check("bp_no_pulse", 128'(write_req_o), 128'(0));
            check("bp_stable", request_o, held);
        end
        check("bp_count", 128'(req_count), 128'(rq0));
        enable_i = 1'b1;
        compute_ready_i = 1'b1;
        wait_reqs("wait_1681", 1681, 5000);
        finish_job(32'h3F80_0000);

        // Held enable after completion must not restart the job
        rq0 = req_count;
        rd0 = rd_count;
        for (int k = 0; k < 50; k++) begin
            step();
            check("done_valid", 128'(result_valid_o), 128'(1));
        end
        check("done_no_req", 128'(req_count), 128'(rq0));
        check("done_no_rd", 128'(rd_count), 128'(rd0));
        enable_i = 1'b0;
        step();
        check("idle_valid", 128'(result_valid_o), 128'(0));
        check("idle_keep", 128'(result_o), 128'(32'h3F80_0000));

        // Empty read: straight to DONE with a zero result
        rd0 = rd_count;
        start_job(0, 41);
        step();
        step();
        check("empty_valid", 128'(result_valid_o), 128'(1));
        check("empty_result", 128'(result_o), 128'(0));
        check("empty_reqs", 128'(req_count - job_start), 128'(0));
        check("empty_rd", 128'(rd_count), 128'(rd0));
        enable_i = 1'b0;
        step();

        // Reset after the 100th request, then a full restart
        start_job(41, 41);
        wait_reqs("wait_100", 100, 1000);
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        check("midreset_outs", all_outs(), 128'(0));
        check("midreset_result", 128'({result_o, result_valid_o}), 128'(0));
        job_start = req_count;
        wait_reqs("restart_1681", 1681, 5000);
        rv = $urandom;
        finish_job(rv);
        enable_i = 1'b0;
        step();

        // Single-cell job
        start_job(1, 1);
        wait_reqs("wait_1x1", 1, 50);
        check("one_flags", 128'(last_req[3:0]), 128'(4'hF));
        rv = $urandom;
        finish_job(rv);
        enable_i = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pairhmm_worker_core.md
Name: pairhmm_worker_core

Overview:
- Per-job sequencer of the PairHMM accelerator.
- Walks the read × haplotype DP matrix in row-major order and fetches read bases, qualities and haplotype bases from external 1-cycle-latency ROM/BRAM ports.
- Packs one request per cell and hands it to a compute engine through a ready/write handshake.
- Collects the engine's single final likelihood and presents it as the job result.

Parameters:
- MAX_SEQUENCE_LENGTH, 2048: max read/hap length. ADDR_WIDTH = $clog2(MAX_SEQUENCE_LENGTH), which is 11 at default.

Ports:
- clock_i  in  1  sole clock, rising edge.
- reset_i  in  1  synchronous, active-low reset.
- enable_i  in  1  job start/hold level.
- read_len_i  in  ADDR_WIDTH  read length, latched at start.
- read_pos_o  out  ADDR_WIDTH  read ROM address (row).
- read_read_o  out  1  read ROM enable.
- read_base_i  in  8  read base (nucleotide_t, ASCII).
- read_q_i, read_i_i, read_d_i, read_c_i  in  8 each  phred quals at row.
- read_i_right_i, read_d_right_i, read_c_right_i  in  8 each  quals at row+1; address offset applied externally.
- hap_len_i  in  ADDR_WIDTH  haplotype length, latched at start.
- hap_pos_o  out  ADDR_WIDTH  hap ROM address (column).
- hap_read_o  out  1  hap ROM enable.
- hap_base_i  in  8  hap base.
- compute_ready_i  in  1  engine can accept a request.
- request_o  out  request_t  packed request.
- write_req_o  out  1  request valid, 1-cycle pulse.
- result_ready_i  in  1  engine result available.
- result_i  in  result_t  engine result; holds floating_point_t value, 32-bit IEEE single.
- read_result_o  out  1  result consumed, 1-cycle pulse.
- result_o  out  32  final likelihood (floating_point_t).
- result_valid_o  out  1  final result valid (level).

Behaviour:
- request_t fields: read_base, hap_base, q, i, d, c, i_right, d_right, c_right; row, col (ADDR_WIDTH each); first_row, last_row, first_col, last_col flags.
- Reset (reset_i==0 at edge): state IDLE. All outputs 0, including result_o and request_o. Reset mid-job aborts immediately with no further requests.
- FSM states: IDLE, FETCH, ISSUE, WAIT_RES, DONE.
- IDLE, enable_i==1:
  - Latch both lengths; row=col=0.
  - If either length is 0: go to DONE with result_o=0.
  - Otherwise go to FETCH.
- FETCH (1 cycle):
  - read_read_o=hap_read_o=1, read_pos_o=row, hap_pos_o=col; go to ISSUE.
  - ROM data is valid the next cycle and stable while the enables stay low.
- ISSUE:
  - request_o is driven combinationally from the ROM data and indices.
  - Flags: first_row=(row==0), last_row=(row==read_len-1), first_col=(col==0), last_col=(col==hap_len-1).
  - When compute_ready_i==1: write_req_o=1 for exactly that cycle.
    - Not the last cell: col++; on the last column, col=0 and row++. Go to FETCH.
    - Last cell: go to WAIT_RES.
  - compute_ready_i==0: hold; request_o stays stable, write_req_o=0.
- Throughput: 1 request per 2 cycles max. Total requests = read_len × hap_len.
- WAIT_RES, result_ready_i==1: read_result_o=1 for that cycle, result_o<=result_i value, go to DONE.
- DONE:
  - result_valid_o=1; result_o is held.
  - Return to IDLE when enable_i==0; result_valid_o drops next cycle and result_o keeps its last value.
- enable_i is sampled only in IDLE and DONE; deassertion mid-job is ignored. Holding enable_i high after DONE does not restart the job.
- read_read_o/hap_read_o are 0 outside FETCH. read_pos_o/hap_pos_o always show the current row/col.

Test Plan:
- 41×41 job, engine always ready, result 0x3F800000 returned 10 cycles after the last request:
  - exactly 1681 write_req_o pulses.
  - First request: row=0, col=0, first_row=1, first_col=1.
  - Request #41: col=40, last_col=1. Request #42: row=1, col=0.
  - Last request: row=40, col=40, last_row=1, last_col=1.
  - Bases/quals match the ROM contents at row/col.
  - One read_result_o pulse; result_o=0x3F800000 with result_valid_o=1.
- Backpressure: compute_ready_i low for 20 cycles during ISSUE -> no pulses; request_o stable; resumes with the same cell; total count unchanged.
- read_len=0, hap_len=41 -> no requests or ROM reads; result_valid_o=1 within 2 cycles of enable; result_o=0.
- reset_i=0 for one cycle after the 100th request -> all outputs 0 next cycle. With enable_i high, a new job restarts at row=0, col=0.
- After DONE, enable_i held high 50 cycles -> result_valid_o stays 1, no new requests. enable_i=0 -> IDLE; re-enable starts a fresh job.
- 1×1 job -> single request with all four flags=1, then result.
